// File: rtl/fact_sched_pkg.sv
// Shared definitions for the factorial job scheduler: FSM encoding,
// CPU and accelerator register selects, and the result word layout.
package fact_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_GO    = 3'd2,
    S_POLL  = 3'd3,
    S_FETCH = 3'd4,
    S_DROP  = 3'd5
  } state_t;

  localparam logic [1:0] REG_OPND = 2'd0;
  localparam logic [1:0] REG_STAT = 2'd1;
  localparam logic [1:0] REG_RSLT = 2'd2;
  localparam logic [1:0] REG_CTRL = 2'd3;

  localparam logic [1:0] ACC_N      = 2'd0;
  localparam logic [1:0] ACC_GO     = 2'd1;
  localparam logic [1:0] ACC_STATUS = 2'd2;
  localparam logic [1:0] ACC_RESULT = 2'd3;

  localparam logic [26:0] FACT_ALL_ONES = 27'h7FFFFFF;

  // Result word: {err, n, fact[26:0]}
  function automatic logic [31:0] pack_result(input logic err, input logic [3:0] n,
                                              input logic [26:0] fact);
    return {err, n, fact};
  endfunction

endpackage

// File: rtl/fact_sched_sync_fifo.sv
// Single-clock FIFO with synchronous flush; a push into a full FIFO is
// accepted when a pop happens in the same cycle.
module sync_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/fact_sched.sv
// CPU-facing factorial job scheduler: queues operands, drives the factorial
// accelerator one job at a time, and queues results for the CPU.
module fact_sched
  import fact_sched_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  a,
  input  logic        we,
  input  logic        re,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        irq,
  output logic [1:0]  acc_a,
  output logic        acc_we,
  output logic [3:0]  acc_wd,
  input  logic [31:0] acc_rd,
  output logic [2:0]  dbg_state
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  state_t          state, state_next;
  logic [3:0]      n;
  logic            err;
  logic [TW-1:0]   tcnt;
  logic            ovf, to_err, irq_en;
  logic            busy;

  logic            opnd_push, opnd_pop, opnd_full, opnd_empty;
  logic [3:0]      opnd_dout;
  logic [CW-1:0]   opnd_cnt;
  logic            res_push, res_pop, res_full, res_empty;
  logic [31:0]     res_din, res_dout;
  logic [CW-1:0]   res_cnt;
  logic            flush, clr_err;
  logic            unused_bits;

  // CPU access: we/re are one-cycle strobes with no backpressure; every
  // access completes in the cycle it is presented and rd is combinational.
  assign opnd_push = we && (a == REG_OPND);
  assign res_pop   = re && (a == REG_RSLT);
  assign flush     = we && (a == REG_CTRL) && wd[1];
  assign clr_err   = we && (a == REG_CTRL) && wd[2];
  assign opnd_pop  = (state == S_IDLE) && !opnd_empty;
  assign busy      = (state != S_IDLE);
  assign irq       = irq_en & ((res_cnt != '0) | to_err);
  assign dbg_state = state;
  assign unused_bits = ^{wd[31:4], acc_rd[31:27]};

  sync_fifo #(.W(4), .DEPTH(DEPTH)) u_opnd_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .push  (opnd_push),
    .din   (wd[3:0]),
    .pop   (opnd_pop),
    .dout  (opnd_dout),
    .full  (opnd_full),
    .empty (opnd_empty),
    .count (opnd_cnt)
  );

  sync_fifo #(.W(32), .DEPTH(DEPTH)) u_res_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .push  (res_push),
    .din   (res_din),
    .pop   (res_pop),
    .dout  (res_dout),
    .full  (res_full),
    .empty (res_empty),
    .count (res_cnt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      n      <= '0;
      err    <= 1'b0;
      tcnt   <= '0;
      ovf    <= 1'b0;
      to_err <= 1'b0;
      irq_en <= 1'b0;
    end else begin
      state <= state_next;
      if (opnd_pop) n <= opnd_dout;
      if (state == S_GO) tcnt <= '0;
      else if (state == S_POLL) tcnt <= tcnt + 1'b1;
      // Error flag is only meaningful on the cycle the accelerator reports done.
      if (state == S_POLL && acc_rd[0]) err <= acc_rd[1];
      if (we && (a == REG_CTRL) && wd[0]) irq_en <= 1'b1;
      if (clr_err) ovf <= 1'b0;
      else if (opnd_push && opnd_full && !opnd_pop) ovf <= 1'b1;
      if (state == S_DROP && !res_full) to_err <= 1'b1;
      else if (clr_err) to_err <= 1'b0;
    end
  end

  always_comb begin
    state_next = state;
    acc_a      = ACC_STATUS;
    acc_we     = 1'b0;
    acc_wd     = 4'd0;
    res_push   = 1'b0;
    res_din    = '0;
    unique case (state)
      S_IDLE: if (!opnd_empty) state_next = S_LOAD;
      S_LOAD: begin
        acc_a      = ACC_N;
        acc_we     = 1'b1;
        acc_wd     = n;
        state_next = S_GO;
      end
      S_GO: begin
        acc_a      = ACC_GO;
        acc_we     = 1'b1;
        acc_wd     = 4'd1;
        state_next = S_POLL;
      end
      S_POLL: begin
        if (acc_rd[0]) state_next = S_FETCH;
        else if (tcnt == TW'(TIMEOUT - 1)) state_next = S_DROP;
      end
      S_FETCH: begin
        acc_a   = ACC_RESULT;
        res_din = pack_result(err, n, acc_rd[26:0]);
        if (!res_full) begin
          res_push   = 1'b1;
          state_next = S_IDLE;
        end
      end
      S_DROP: begin
        res_din = pack_result(1'b1, n, FACT_ALL_ONES);
        if (!res_full) begin
          res_push   = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    rd = '0;
    unique case (a)
      REG_STAT: rd = {ovf, to_err, irq_en, busy, 12'b0, 8'(res_cnt), 8'(opnd_cnt)};
      REG_RSLT: rd = res_empty ? 32'd0 : res_dout;
      REG_CTRL: rd = {31'b0, irq_en};
      default:  rd = '0;
    endcase
  end

endmodule
